// File: rtl/uart_rx_deserializer_if.sv
// Receive-side signal bundle between the UART clock generator / serial pin
// and the CSR block: oversample tick, serial line, and deserialised byte outputs.
interface uart_rx_deserializer_if;
  logic       sck_rising_edge;
  logic       sin;
  logic       busy;
  logic       rx_data_valid;
  logic [7:0] rx_data;
  logic       error;

  modport master (
    output sck_rising_edge,
    output sin,
    input  busy,
    input  rx_data_valid,
    input  rx_data,
    input  error
  );

  modport slave (
    input  sck_rising_edge,
    input  sin,
    output busy,
    output rx_data_valid,
    output rx_data,
    output error
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART 8N1 receiver: two-flop synchroniser, start detection, 2-of-3 mid-bit
// majority sampling on the oversample tick, and one-cycle valid/error pulses.
module uart_rx_deserializer #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  uart_rx_deserializer_if.slave rx
);

  localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
  localparam logic [CntW-1:0] CntS0   = CntW'(OVERSAMPLE / 2 - 1);
  localparam logic [CntW-1:0] CntS1   = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] CntS2   = CntW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitIdle} state_e;

  state_e          state_q;
  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_nxt;
  logic [2:0]      bitn_q;
  logic [7:0]      shift_q;
  logic [7:0]      rx_data_q;
  logic            samp0_q, samp1_q;
  logic            busy_q, valid_q, error_q;
  logic            sin_s, tick, at_s0, at_s1, at_decide, at_wrap, vote, running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx.sin};
    end
  end

  assign sin_s     = sync_q[1];
  assign tick      = rx.sck_rising_edge;
  assign at_s0     = tick && (cnt_q == CntS0);
  assign at_s1     = tick && (cnt_q == CntS1);
  assign at_decide = tick && (cnt_q == CntS2);
  assign at_wrap   = tick && (cnt_q == CntLast);
  assign cnt_nxt   = at_wrap ? '0 : cnt_q + CntW'(1);
  assign running   = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  // Third sample is taken live from sin_s on the deciding edge.
  assign vote      = (samp0_q & samp1_q) | (samp0_q & sin_s) | (samp1_q & sin_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bitn_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      samp0_q   <= 1'b1;
      samp1_q   <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (running && tick) begin
        cnt_q <= cnt_nxt;
        if (at_s0) samp0_q <= sin_s;
        if (at_s1) samp1_q <= sin_s;
      end
      unique case (state_q)
        StIdle: begin
          if (!sin_s) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        StStart: begin
          if (at_decide && vote) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (at_wrap) begin
            state_q <= StData;
            bitn_q  <= '0;
          end
        end
        StData: begin
          if (at_decide) shift_q[bitn_q] <= vote;
          if (at_wrap) begin
            if (bitn_q == 3'd7) state_q <= StStop;
            else                bitn_q  <= bitn_q + 3'd1;
          end
        end
        StStop: begin
          // Leave at mid-bit so a back-to-back start edge is not missed.
          if (at_decide) begin
            if (vote) begin
              rx_data_q <= shift_q;
              valid_q   <= 1'b1;
              state_q   <= StIdle;
              busy_q    <= 1'b0;
            end else begin
              error_q <= 1'b1;
              state_q <= StWaitIdle;
            end
          end
        end
        StWaitIdle: begin
          if (sin_s) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.busy          = busy_q;
  assign rx.rx_data_valid = valid_q;
  assign rx.rx_data       = rx_data_q;
  assign rx.error         = error_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench for uart_rx_deserializer: frames are driven tick by tick
// and the observed pulses are compared against timings computed from frame rules.
module tb_uart_rx_deserializer;

  localparam int unsigned OS  = 16;
  localparam int unsigned LAT = 5 + 9 * OS + OS / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  uart_rx_deserializer_if rx_if ();

  uart_rx_deserializer #(.OVERSAMPLE(OS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  always #5 clk = ~clk;

  int unsigned edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int unsigned e;
    logic [7:0]  d;
    logic        err;
  } ev_t;

  ev_t         evq[$];
  int unsigned both_cnt  = 0;
  int unsigned rise_e    = 0;
  int unsigned fall_e    = 0;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_if.rx_data_valid === 1'b1) evq.push_back('{e: edge_n, d: rx_if.rx_data, err: 1'b0});
    if (rx_if.error === 1'b1)         evq.push_back('{e: edge_n, d: rx_if.rx_data, err: 1'b1});
    if (rx_if.rx_data_valid === 1'b1 && rx_if.error === 1'b1) both_cnt++;
    if (rx_if.busy === 1'b1 && busy_prev === 1'b0) rise_e = edge_n;
    if (rx_if.busy === 1'b0 && busy_prev === 1'b1) fall_e = edge_n;
    busy_prev = rx_if.busy;
  end

  int unsigned tick_div   = 1;
  int unsigned tick_phase = 0;
  int unsigned hold_left  = 0;

  task automatic step(output bit ticked);
    @(negedge clk);
    if (hold_left > 0) begin
      rx_if.sck_rising_edge = 1'b0;
      hold_left--;
    end else begin
      rx_if.sck_rising_edge = (tick_phase == 0);
      tick_phase = (tick_phase + 1) % tick_div;
    end
    ticked = rx_if.sck_rising_edge;
  endtask

  task automatic idle(input int unsigned n);
    bit t;
    for (int i = 0; i < int'(n); i++) step(t);
  endtask

  // Drives one frame counted in oversample ticks; optional glitch, tick hold, or reset.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int gbit,
                            input int gpos, input int hbit, input int rbit,
                            output int unsigned e0, output bit aborted);
    logic [9:0] bits;
    bit         t;
    bit         first;
    int         n;
    bits       = {stop, d, 1'b0};
    tick_phase = 0;
    aborted    = 1'b0;
    first      = 1'b1;
    e0         = 0;
    for (int k = 0; k < 10; k++) begin
      n = 0;
      if (k == hbit) hold_left = 50;
      while (n < int'(OS)) begin
        step(t);
        rx_if.sin = (k == gbit && n == gpos) ? ~bits[k] : bits[k];
        if (first) e0 = edge_n;
        first = 1'b0;
        if (k == rbit && n == 8) begin
          rst_n   = 1'b0;
          aborted = 1'b1;
          return;
        end
        if (t) n++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_if.sin = 1'b1;
    rx_if.sck_rising_edge = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_if.busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b want 0", rx_if.busy); end
    checks++; if (rx_if.rx_data_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", rx_if.rx_data_valid); end
    checks++; if (rx_if.rx_data !== 8'h00) begin errors++;
      $display("FAIL reset_data got %h want 00", rx_if.rx_data); end
    checks++; if (rx_if.error !== 1'b0) begin errors++;
      $display("FAIL reset_error got %b want 0", rx_if.error); end
    rst_n = 1'b1;
    idle(5);
    checks++; if (rx_if.busy !== 1'b0) begin errors++;
      $display("FAIL post_reset_busy got %b want 0", rx_if.busy); end
  endtask

  task automatic test_nominal();
    int unsigned e0;
    bit ab;
    evq.delete();
    send_frame(8'h55, 1'b1, -1, -1, -1, -1, e0, ab);
    idle(20);
    checks++;
    if (evq.size() != 1 || evq[0].err !== 1'b0 || evq[0].d !== 8'h55 || evq[0].e != e0 + LAT)
    begin
      errors++;
      $display("FAIL nominal_pulse got n=%0d d=%h err=%b edge=%0d want n=1 d=55 err=0 edge=%0d",
               evq.size(), (evq.size() > 0) ? evq[0].d : 8'hxx,
               (evq.size() > 0) ? evq[0].err : 1'bx,
               (evq.size() > 0) ? evq[0].e - e0 : 0, LAT);
    end
    checks++; if (rise_e != e0 + 3) begin errors++;
      $display("FAIL nominal_busy_rise got %0d want 3", rise_e - e0); end
    checks++; if (fall_e != e0 + LAT) begin errors++;
      $display("FAIL nominal_busy_fall got %0d want %0d", fall_e - e0, LAT); end
    checks++; if (rx_if.rx_data !== 8'h55) begin errors++;
      $display("FAIL nominal_data_held got %h want 55", rx_if.rx_data); end
  endtask

  task automatic test_framing();
    int unsigned e0, r;
    bit ab, t;
    evq.delete();
    send_frame(8'hA5, 1'b0, -1, -1, -1, -1, e0, ab);
    idle(100);
    checks++; if (rx_if.busy !== 1'b1) begin errors++;
      $display("FAIL framing_busy_break got %b want 1", rx_if.busy); end
    step(t);
    rx_if.sin = 1'b1;
    r = edge_n;
    idle(10);
    checks++;
    if (evq.size() != 1 || evq[0].err !== 1'b1 || evq[0].e != e0 + LAT) begin
      errors++;
      $display("FAIL framing_pulse got n=%0d err=%b edge=%0d want n=1 err=1 edge=%0d",
               evq.size(), (evq.size() > 0) ? evq[0].err : 1'bx,
               (evq.size() > 0) ? evq[0].e - e0 : 0, LAT);
    end
    checks++; if (rx_if.rx_data !== 8'h55) begin errors++;
      $display("FAIL framing_data_kept got %h want 55", rx_if.rx_data); end
    checks++; if (fall_e != r + 3) begin errors++;
      $display("FAIL framing_busy_fall got %0d want %0d", fall_e, r + 3); end
  endtask

  task automatic test_false_start();
    int unsigned e0;
    bit t;
    evq.delete();
    step(t);
    rx_if.sin = 1'b0;
    e0 = edge_n;
    idle(3);
    step(t);
    rx_if.sin = 1'b1;
    idle(30);
    checks++; if (evq.size() != 0) begin errors++;
      $display("FAIL false_start_pulses got %0d want 0", evq.size()); end
    checks++; if (rise_e != e0 + 3 || fall_e != e0 + 13) begin errors++;
      $display("FAIL false_start_busy got rise=%0d fall=%0d want rise=3 fall=13",
               rise_e - e0, fall_e - e0); end
  endtask

  task automatic test_glitch();
    int unsigned e0;
    bit ab;
    evq.delete();
    // Position 9 of data bit 3 lands on the middle vote sample.
    send_frame(8'hFF, 1'b1, 4, 9, -1, -1, e0, ab);
    idle(20);
    checks++;
    if (evq.size() != 1 || evq[0].d !== 8'hFF || evq[0].err !== 1'b0) begin
      errors++;
      $display("FAIL glitch_vote got n=%0d d=%h want n=1 d=ff",
               evq.size(), (evq.size() > 0) ? evq[0].d : 8'hxx);
    end
  endtask

  task automatic test_back_to_back();
    int unsigned ea, eb;
    bit ab;
    evq.delete();
    send_frame(8'h00, 1'b1, -1, -1, -1, -1, ea, ab);
    send_frame(8'hFF, 1'b1, -1, -1, -1, -1, eb, ab);
    idle(20);
    checks++;
    if (evq.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d want 2", evq.size());
    end else begin
      checks++;
      if (evq[0].d !== 8'h00 || evq[1].d !== 8'hFF || evq[0].err || evq[1].err) begin
        errors++;
        $display("FAIL b2b_data got %h,%h want 00,ff", evq[0].d, evq[1].d);
      end
      checks++;
      if (evq[0].e != ea + LAT || evq[1].e - evq[0].e != 10 * OS) begin
        errors++;
        $display("FAIL b2b_spacing got first=%0d gap=%0d want first=%0d gap=%0d",
                 evq[0].e - ea, evq[1].e - evq[0].e, LAT, 10 * OS);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] d, model_data;
    logic stop;
    int unsigned e0;
    bit ab, t;
    model_data = rx_if.rx_data;
    for (int i = 0; i < 8; i++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      evq.delete();
      send_frame(d, stop, -1, -1, -1, -1, e0, ab);
      if (!stop) begin
        idle($urandom_range(0, 40));
        step(t);
        rx_if.sin = 1'b1;
      end
      idle(20 + $urandom_range(0, 10));
      if (stop) model_data = d;
      checks++;
      if (evq.size() != 1 || evq[0].err !== ~stop || evq[0].e != e0 + LAT ||
          rx_if.rx_data !== model_data) begin
        errors++;
        $display("FAIL random_frame%0d got n=%0d err=%b data=%h want n=1 err=%b data=%h",
                 i, evq.size(), (evq.size() > 0) ? evq[0].err : 1'bx, rx_if.rx_data,
                 ~stop, model_data);
      end
    end
  endtask

  task automatic test_slow_tick();
    int unsigned e0, lat_plain, lat_hold;
    bit ab;
    tick_div = 4;
    // First tick after START entry lands 5 edges in; the stop decision is tick 9*OS+OS/2+2.
    lat_plain = 1 + tick_div * (9 * OS + OS / 2 + 2);
    lat_hold  = lat_plain + 50;
    evq.delete();
    send_frame(8'h3C, 1'b1, -1, -1, -1, -1, e0, ab);
    idle(40);
    checks++;
    if (evq.size() != 1 || evq[0].d !== 8'h3C || evq[0].e != e0 + lat_plain) begin
      errors++;
      $display("FAIL slow_tick got n=%0d d=%h lat=%0d want n=1 d=3c lat=%0d", evq.size(),
               (evq.size() > 0) ? evq[0].d : 8'hxx, (evq.size() > 0) ? evq[0].e - e0 : 0,
               lat_plain);
    end
    evq.delete();
    send_frame(8'h3C, 1'b1, -1, -1, 5, -1, e0, ab);
    idle(40);
    checks++;
    if (evq.size() != 1 || evq[0].d !== 8'h3C || evq[0].e != e0 + lat_hold) begin
      errors++;
      $display("FAIL slow_tick_hold got n=%0d d=%h lat=%0d want n=1 d=3c lat=%0d", evq.size(),
               (evq.size() > 0) ? evq[0].d : 8'hxx, (evq.size() > 0) ? evq[0].e - e0 : 0,
               lat_hold);
    end
    tick_div   = 1;
    tick_phase = 0;
  endtask

  task automatic test_mid_reset();
    int unsigned e0;
    bit ab;
    evq.delete();
    send_frame(8'h81, 1'b1, -1, -1, -1, 5, e0, ab);
    #1;
    checks++;
    if (!ab || rx_if.busy !== 1'b0 || rx_if.rx_data_valid !== 1'b0 || rx_if.error !== 1'b0 ||
        rx_if.rx_data !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_outputs got busy=%b v=%b err=%b d=%h want 0 0 0 00",
               rx_if.busy, rx_if.rx_data_valid, rx_if.error, rx_if.rx_data);
    end
    rx_if.sin = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(30);
    checks++; if (evq.size() != 0) begin errors++;
      $display("FAIL mid_reset_pulses got %0d want 0", evq.size()); end
    send_frame(8'h81, 1'b1, -1, -1, -1, -1, e0, ab);
    idle(20);
    checks++;
    if (evq.size() != 1 || evq[0].d !== 8'h81 || evq[0].e != e0 + LAT) begin
      errors++;
      $display("FAIL mid_reset_recover got n=%0d d=%h want n=1 d=81", evq.size(),
               (evq.size() > 0) ? evq[0].d : 8'hxx);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_if.sin = 1'b1;
    rx_if.sck_rising_edge = 1'b0;
    test_reset();
    test_nominal();
    test_framing();
    test_false_start();
    test_glitch();
    test_back_to_back();
    test_random();
    test_slow_tick();
    test_mid_reset();
    checks++; if (both_cnt != 0) begin errors++;
      $display("FAIL exclusivity got %0d overlaps want 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
# uart_rx_deserializer

Receive front-end of the UART peripheral: synchronises the asynchronous `sin` line and detects start bits. It majority-samples each bit at the oversampled tick from the UART clock generator, deserialises 8N1 frames LSB-first and hands each byte to the UART CSR block as a one-cycle `rx_data_valid` pulse, with a one-cycle `error` pulse on framing errors. The CSR block consumes `rx_data`/`rx_data_valid`/`error` to update RDR, SR.rxne, SR.rxerr and ISR.rxnef; `busy` is informational.

## Interface
- `OVERSAMPLE`, 16: `sck_rising_edge` pulses per bit period; even, ≥ 4.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sck_rising_edge` in 1: oversample tick, one-`clk` pulse, OVERSAMPLE per bit; low whenever the UART is disabled.
- `sin` in 1: serial input, asynchronous, idle high.
- `busy` out 1: high from start detection until return to IDLE.
- `rx_data_valid` out 1: one-cycle pulse, a valid frame has been received.
- `rx_data` out 8: last valid byte; updated only together with `rx_data_valid`, held otherwise.
- `error` out 1: one-cycle pulse, framing error (stop bit sampled 0).

## Operation
- **Synchroniser:** 2 flops; reset value 1; output `sin_s`. All logic uses `sin_s` only.
- **Tick counter:** `cnt`, width clog2(OVERSAMPLE). It advances only on `sck_rising_edge` and wraps OVERSAMPLE-1 → 0. Bit index `bitn` runs 0..7.
- **Sampling:** in each bit, `sin_s` is sampled on ticks with `cnt` = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided on the third sample's edge using that edge's sample.
- **States:**
  - IDLE:
    - `sin_s`==0 → START, `cnt`=0. No tick is required for detection.
  - START:
    - At the decision point, majority 1 → IDLE (false start; no output pulses).
    - Majority 0 → continue; on the tick with `cnt`==OVERSAMPLE-1 → DATA, `bitn`=0.
  - DATA:
    - The decided bit is shifted into a shift register at bit position `bitn`.
    - On the wrap tick: `bitn`==7 → STOP, else `bitn`++.
  - STOP:
    - At the decision point, majority 1 → `rx_data`←shift register, `rx_data_valid`=1 for one cycle, → IDLE.
      - STOP exits at mid-bit, not at end of bit, so back-to-back frames resynchronise on the next falling edge.
    - Majority 0 → `error`=1 for one cycle, `rx_data` unchanged, → WAIT_IDLE.
  - WAIT_IDLE:
    - Stays until `sin_s`==1, then → IDLE. A held-low line (break) yields exactly one `error` pulse.
- **`busy`:** `busy` = (state ≠ IDLE), registered with the state.
- **Tick held low:** `cnt`, `bitn` and state freeze; no timeout.
- **Exclusivity:** `rx_data_valid` and `error` are never high simultaneously.

## Timing
- **Reset:** `busy`=0, `rx_data_valid`=0, `rx_data`=8'h00, `error`=0, state IDLE, `cnt`=0, `bitn`=0, sync flops=1.
- **Mid-frame reset:** `rst_n` low mid-frame aborts immediately with no pulse. After release the block waits for a fresh falling edge; a line already low is treated as a start.
- **Reference edge numbering (`sck_rising_edge` tied high):** `sin` falls between edges 0 and 1.
  - `sin_s` is low after edge 2.
  - START is entered at edge 3.
  - Bit k (0 = start, 1..8 = data, 9 = stop) is decided at edge 3 + k·OVERSAMPLE + OVERSAMPLE/2 + 2.
- **Output latency:** `rx_data_valid`/`error` are high during the cycle after edge 5 + 9·OVERSAMPLE + OVERSAMPLE/2, i.e. after edge 157 for OVERSAMPLE=16.
- **Return to IDLE:** in the same edge as the pulse (valid frame); `busy` falls on that edge.
- **Throughput:** a new start can be detected two edges after the IDLE return at the earliest.

## Test plan
- **Nominal frame:** OVERSAMPLE=16, tick tied high, frame 0x55 (bit period 16 clk) → `rx_data_valid` single pulse after edge 157, `rx_data`=8'h55, `error` stays 0, `busy` high edges 3..157.
- **Framing error:** frame 0xA5 with stop bit 0, previous byte 0x55 → one `error` pulse after edge 157, no `rx_data_valid`, `rx_data` stays 8'h55. `busy` stays high until `sin` returns high + 2 edges.
- **False start and noise:**
  - `sin` low for 4 clk, then high → `busy` pulses for ≤ 12 cycles, no `rx_data_valid`/`error`.
  - One-clk low glitch at the centre of data bit 3 of 0xFF → `rx_data`=8'hFF (majority vote).
- **Back-to-back frames:** 0x00 then 0xFF (stop bit exactly 16 clk) → two `rx_data_valid` pulses exactly 160 clk apart, data 8'h00 then 8'hFF.
- **Slow tick:** `sck_rising_edge` every 4th clk, frame 0x3C → `rx_data`=8'h3C. Holding the tick low for 50 clk mid-frame only delays completion by 50 clk.
- **Mid-frame reset:** `rst_n` low during data bit 4 → all outputs 0 immediately, no pulses. The next full frame 0x81 is received correctly.
